// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
package reg_file_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;

   // Write lane indices; lane 1 wins every same-address collision.
   localparam int LANE0 = 0;
   localparam int LANE1 = 1;

   // Address width for a power-of-two register count (at least 1 bit).
   function automatic int addr_width(input int nregs);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < nregs) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set by issue
// reservations, cleared by writeback or a flush, with a registered popcount.
import reg_file_pkg::*;

module reg_scoreboard #(
   parameter int NREGS    = DEF_NREGS,
   parameter int ZERO_REG = 1,
   parameter int AW       = addr_width(NREGS)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        clr_valid,
   input  logic [2*AW-1:0]   clr_address,
   input  logic              reserve_valid,
   input  logic [AW-1:0]     reserve_address,
   input  logic              flush,
   output logic [NREGS-1:0]  busy,
   output logic [AW:0]       busy_count
);

   logic [NREGS-1:0] busy_d, busy_q;
   logic [AW:0]      busy_count_d, busy_count_q;
   logic             reserve_ok;

   // Register 0 never becomes busy when it is hardwired to zero.
   assign reserve_ok = reserve_valid && !(ZERO_REG != 0 && reserve_address == '0);

   // Retire clears first, then a reservation sets, so a new producer wins;
   // flush overrides both and drops the reservation.
   always_comb begin
      busy_d = busy_q;
      if (clr_valid[LANE0]) busy_d[clr_address[LANE0*AW +: AW]] = 1'b0;
      if (clr_valid[LANE1]) busy_d[clr_address[LANE1*AW +: AW]] = 1'b0;
      if (flush) begin
         busy_d = '0;
      end else if (reserve_ok) begin
         busy_d[reserve_address] = 1'b1;
      end
   end

   // Popcount of the next busy vector, so the count is aligned with it.
   always_comb begin
      busy_count_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_count_d = busy_count_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   // Busy vector and count state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign busy       = busy_q;
   assign busy_count = busy_count_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised integer register file: NREAD combinational read ports, two
// writeback lanes (lane 1 wins collisions), optional write-to-read bypass and
// an integrated busy-bit scoreboard for in-order hazard detection.
import reg_file_pkg::*;

module reg_file_sb #(
   parameter int XLEN     = DEF_XLEN,
   parameter int NREGS    = DEF_NREGS,
   parameter int NREAD    = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                                   clock,
   input  logic                                   reset_n,
   input  logic [NREAD*addr_width(NREGS)-1:0]     read_address,
   output logic [NREAD*XLEN-1:0]                  read_data,
   output logic [NREAD-1:0]                       read_busy,
   input  logic [1:0]                             write_enable,
   input  logic [2*addr_width(NREGS)-1:0]         write_address,
   input  logic [2*XLEN-1:0]                      write_data,
   input  logic                                   reserve_valid,
   input  logic [addr_width(NREGS)-1:0]           reserve_address,
   input  logic                                   flush,
   output logic [addr_width(NREGS):0]             busy_count
);

   localparam int AW = addr_width(NREGS);

   logic [NREGS-1:0][XLEN-1:0] regs_d, regs_q;
   logic [NREGS-1:0]           busy;
   logic [AW-1:0]              wa0, wa1;
   logic [XLEN-1:0]            wd0, wd1;
   logic                       we0, we1;

   assign we0 = write_enable[LANE0];
   assign we1 = write_enable[LANE1];
   assign wa0 = write_address[LANE0*AW +: AW];
   assign wa1 = write_address[LANE1*AW +: AW];
   assign wd0 = write_data[LANE0*XLEN +: XLEN];
   assign wd1 = write_data[LANE1*XLEN +: XLEN];

   // Lane 0 applied first so lane 1 overwrites it on an address collision;
   // writes to a hardwired-zero register 0 are dropped.
   always_comb begin
      regs_d = regs_q;
      if (we0 && !(ZERO_REG != 0 && wa0 == '0)) regs_d[wa0] = wd0;
      if (we1 && !(ZERO_REG != 0 && wa1 == '0)) regs_d[wa1] = wd1;
   end

   // Register array state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) regs_q <= '0;
      else          regs_q <= regs_d;
   end

   reg_scoreboard #(
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_sb (
      .clock           (clock),
      .reset_n         (reset_n),
      .clr_valid       (write_enable),
      .clr_address     (write_address),
      .reserve_valid   (reserve_valid),
      .reserve_address (reserve_address),
      .flush           (flush),
      .busy            (busy),
      .busy_count      (busy_count)
   );

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic            hit0, hit1, is_zero;
      logic [XLEN-1:0] rd;

      assign ra      = read_address[i*AW +: AW];
      assign hit0    = we0 && (wa0 == ra);
      assign hit1    = we1 && (wa1 == ra);
      assign is_zero = (ZERO_REG != 0) && (ra == '0);

      // Array read, overridden by same-cycle write data (lane 1 first),
      // with register 0 forced to zero last.
      always_comb begin
         rd = regs_q[ra];
         if (BYPASS != 0) begin
            if (hit1)      rd = wd1;
            else if (hit0) rd = wd0;
         end
         if (is_zero) rd = '0;
      end

      assign read_data[i*XLEN +: XLEN] = rd;
      // A producer retiring this cycle is already forwarded, so no hazard.
      assign read_busy[i] = busy[ra] && !is_zero
                            && !((BYPASS != 0) && (hit0 || hit1));
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed table, reset corner cases and random
// traffic checked against an array-based reference model.
module tb_reg_file_sb;

   localparam int XLEN = 32, NREGS = 32, NREAD = 2, AW = 5;

   logic                  clock = 1'b0;
   logic                  reset_n;
   logic [NREAD*AW-1:0]   read_address;
   logic [NREAD*XLEN-1:0] read_data;
   logic [NREAD-1:0]      read_busy;
   logic [1:0]            write_enable;
   logic [2*AW-1:0]       write_address;
   logic [2*XLEN-1:0]     write_data;
   logic                  reserve_valid;
   logic [AW-1:0]         reserve_address;
   logic                  flush;
   logic [AW:0]           busy_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] mreg  [NREGS];
   bit          mbusy [NREGS];

   typedef struct {
      logic [1:0]  we;
      int          wa0;
      logic [31:0] wd0;
      int          wa1;
      logic [31:0] wd1;
      bit          rv;
      int          rva;
      bit          fl;
      int          ra0;
      int          ra1;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      bit          e_bz0;
      bit          e_bz1;
      int          e_cnt;
   } vec_t;

   reg_file_sb #(
      .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1), .ZERO_REG(1)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .read_address    (read_address),
      .read_data       (read_data),
      .read_busy       (read_busy),
      .write_enable    (write_enable),
      .write_address   (write_address),
      .write_data      (write_data),
      .reserve_valid   (reserve_valid),
      .reserve_address (reserve_address),
      .flush           (flush),
      .busy_count      (busy_count)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] we, input int wa0, input logic [31:0] wd0,
                               input int wa1, input logic [31:0] wd1, input bit rv,
                               input int rva, input bit fl, input int ra0, input int ra1,
                               input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                               input bit e_bz0, input bit e_bz1, input int e_cnt);
      vec_t v;
      v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.rv = rv; v.rva = rva; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
      v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_bz0 = e_bz0; v.e_bz1 = e_bz1; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      write_enable    = v.we;
      write_address   = {AW'(v.wa1), AW'(v.wa0)};
      write_data      = {v.wd1, v.wd0};
      reserve_valid   = v.rv;
      reserve_address = AW'(v.rva);
      flush           = v.fl;
      read_address    = {AW'(v.ra1), AW'(v.ra0)};
   endtask

   // Reference model: architectural view of the register file.
   function automatic logic [31:0] m_rd(input vec_t v, input int a);
      if (a == 0) return 32'h0;
      if (v.we[1] && v.wa1 == a) return v.wd1;
      if (v.we[0] && v.wa0 == a) return v.wd0;
      return mreg[a];
   endfunction

   function automatic bit m_bz(input vec_t v, input int a);
      if (a == 0) return 1'b0;
      if ((v.we[1] && v.wa1 == a) || (v.we[0] && v.wa0 == a)) return 1'b0;
      return mbusy[a];
   endfunction

   task automatic m_edge(input vec_t v);
      if (v.we[0] && v.wa0 != 0) mreg[v.wa0] = v.wd0;
      if (v.we[1] && v.wa1 != 0) mreg[v.wa1] = v.wd1;
      if (v.we[0]) mbusy[v.wa0] = 1'b0;
      if (v.we[1]) mbusy[v.wa1] = 1'b0;
      if (v.fl) begin
         for (int i = 0; i < NREGS; i++) mbusy[i] = 1'b0;
      end else if (v.rv && v.rva != 0) begin
         mbusy[v.rva] = 1'b1;
      end
   endtask

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < NREGS; i++) c += int'(mbusy[i]);
      return c;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NREGS; i++) begin
         mreg[i]  = 32'h0;
         mbusy[i] = 1'b0;
      end
   endtask

   // One cycle: drive, check combinational outputs, clock, check count.
   task automatic step(input vec_t v, input bit use_tbl, input string tag);
      logic [31:0] erd0, erd1;
      bit          ebz0, ebz1;
      int          ecnt;
      @(negedge clock);
      drive(v);
      #1;
      erd0 = use_tbl ? v.e_rd0 : m_rd(v, v.ra0);
      erd1 = use_tbl ? v.e_rd1 : m_rd(v, v.ra1);
      ebz0 = use_tbl ? v.e_bz0 : m_bz(v, v.ra0);
      ebz1 = use_tbl ? v.e_bz1 : m_bz(v, v.ra1);
      chk({tag, " rd0"}, read_data[31:0], erd0);
      chk({tag, " rd1"}, read_data[63:32], erd1);
      chk({tag, " busy0"}, 32'(read_busy[0]), 32'(ebz0));
      chk({tag, " busy1"}, 32'(read_busy[1]), 32'(ebz1));
      @(posedge clock);
      m_edge(v);
      #1;
      ecnt = use_tbl ? v.e_cnt : m_cnt();
      chk({tag, " busy_count"}, 32'(busy_count), 32'(ecnt));
   endtask

   vec_t tbl[$];
   vec_t idle;
   vec_t v;

   initial begin
      idle = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      drive(idle);
      m_reset();
      #1;
      chk("por busy_count", 32'(busy_count), 32'h0);
      chk("por rd0", read_data[31:0], 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Fill every register with ones and leave a batch of reservations.
      for (int k = 0; k < NREGS / 2; k++) begin
         v = mk(2'b11, 2 * k, 32'hFFFF_FFFF, 2 * k + 1, 32'hFFFF_FFFF, 1, k + 1, 0,
                2 * k, 2 * k + 1, 0, 0, 0, 0, 0);
         step(v, 1'b0, "fill");
      end

      // Mid-cycle asynchronous reset: outputs clear with no clock edge.
      @(negedge clock);
      drive(idle);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async rst busy_count", 32'(busy_count), 32'h0);
      for (int a = 0; a < NREGS; a++) begin
         read_address = {AW'(a), AW'(a)};
         #1;
         chk("async rst rd0", read_data[31:0], 32'h0);
         chk("async rst busy0", 32'(read_busy[0]), 32'h0);
      end
      // A write presented while reset is held must not land.
      v = mk(2'b01, 5, 32'h0000_FFFF, 0, 0, 1, 5, 0, 5, 5, 0, 0, 0, 0, 0);
      drive(v);
      @(posedge clock);
      #1;
      drive(idle);
      read_address = {AW'(5), AW'(5)};
      #1;
      chk("rst abort write", read_data[31:0], 32'h0);
      chk("rst abort reserve", 32'(busy_count), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      m_reset();

      // Directed table: we wa0 wd0 wa1 wd1 rv rva fl ra0 ra1 | rd0 rd1 bz0 bz1 cnt
      tbl.push_back(mk(2'b11, 5, 32'h1111_1111, 5, 32'h2222_2222, 0, 0, 0, 5, 5, 32'h2222_2222, 32'h2222_2222, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'h2222_2222, 0, 0, 0, 0));
      tbl.push_back(mk(2'b01, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'h2222_2222, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 1, 1, 1));
      tbl.push_back(mk(2'b01, 7, 32'h0000_1234, 0, 0, 0, 0, 0, 7, 5, 32'h0000_1234, 32'h2222_2222, 0, 0, 0));
      tbl.push_back(mk(2'b10, 0, 0, 3, 32'hCAFE_0003, 1, 3, 0, 3, 7, 32'hCAFE_0003, 32'h0000_1234, 0, 0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 3, 32'hCAFE_0003, 32'hCAFE_0003, 1, 1, 1));
      tbl.push_back(mk(2'b01, 3, 32'h0000_0033, 0, 0, 0, 0, 0, 3, 0, 32'h0000_0033, 0, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 2, 0, 1, 2, 0, 0, 1, 0, 2));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 4, 0, 2, 4, 0, 0, 1, 0, 3));
      tbl.push_back(mk(2'b01, 2, 32'h0000_ABCD, 0, 0, 1, 6, 1, 2, 6, 32'h0000_ABCD, 0, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2, 6, 32'h0000_ABCD, 0, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b11, 10, 32'hAAAA_0010, 11, 32'hBBBB_0011, 0, 0, 0, 10, 11, 32'hAAAA_0010, 32'hBBBB_0011, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 11, 10, 32'hBBBB_0011, 32'hAAAA_0010, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 0, 0, 0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 10, 0, 32'hAAAA_0010, 1, 0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 1));
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

      // Random traffic, addresses mostly in a small window to force collisions.
      for (int n = 0; n < 400; n++) begin
         v = idle;
         v.we  = 2'($urandom_range(0, 3));
         v.wa0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         v.wa1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         v.wd0 = $urandom;
         v.wd1 = $urandom;
         v.rv  = 1'($urandom_range(0, 1));
         v.rva = int'($urandom_range(0, 7));
         v.fl  = ($urandom_range(0, 15) == 0);
         v.ra0 = int'($urandom_range(0, 7));
         v.ra1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         step(v, 1'b0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor of the core's integer register file.
- Adds configurable width and depth, NREAD combinational read ports, and two write ports with defined collision priority.
- Adds optional write-to-read bypass and an integrated busy-bit scoreboard for in-order pipeline hazard detection.
- Sits between decode/issue (reads, reservations) and writeback (two retire lanes).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, minimum 2.
- NREAD, 2, number of read ports; range 1..4.
- BYPASS, 1, 1 forwards same-cycle write data to read ports; 0 reads return array contents only.
- ZERO_REG, 1, 1 hardwires register 0 to zero and makes it never busy.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- read_address  input  NREAD*AW  packed read addresses, port i at bits [i*AW +: AW]; AW = log2(NREGS).
- read_data  output  NREAD*XLEN  packed read data.
- read_busy  output  NREAD  per-port flag: register has an outstanding, unretired producer.
- write_enable  input  2  per-lane write strobe.
- write_address  input  2*AW  packed write addresses.
- write_data  input  2*XLEN  packed write data.
- reserve_valid  input  1  issue is claiming a destination register.
- reserve_address  input  AW  destination being claimed.
- flush  input  1  discard all outstanding reservations.
- busy_count  output  AW+1  number of currently busy registers.

Behaviour:
- Reset: reset_n low asynchronously clears every register to 0, clears every busy bit, and sets busy_count to 0. Outputs are valid combinationally from the cleared state. Reset asserted mid-operation aborts pending writes that cycle.
- Reads are combinational with zero latency: read_data[i] = reg[read_address[i]].
- BYPASS=1: if any write lane is enabled with write_address == read_address[i], read_data[i] returns that lane's write_data. Lane 1 has priority over lane 0. Applies to every read port independently.
- ZERO_REG=1:
  - Reads of address 0 return 0 regardless of bypass.
  - Writes to address 0 are dropped.
  - Reserve of address 0 is ignored.
  - read_busy is always 0 for address 0.
- Writes take effect on the rising edge.
  - Both lanes enabled to the same address: lane 1 data is stored.
  - Different addresses: both are stored.
- Scoreboard: one busy bit per register, updated on the rising edge in this order:
  - An enabled write clears the busy bit of its address.
  - reserve_valid sets the busy bit of reserve_address.
  - Reserve and write to the same address in one cycle: the bit ends set (the new producer wins).
  - Reserving an already-busy register keeps it busy. Single-bit tracking; no counting per register.
- flush: clears all busy bits on the next edge. A reserve in the same cycle is dropped. Writes in the same cycle still commit their data.
- read_busy[i] = busy[read_address[i]]. With BYPASS=1 it is masked to 0 when a write to that address is enabled in the current cycle.
- busy_count is registered and equals the popcount of the busy vector after each edge; its range is 0..NREGS.
- Out-of-range addresses cannot occur, because NREGS is a power of two.

Decomposition:
- reg_file_pkg holds:
  - default XLEN and NREGS constants;
  - localparam function for AW;
  - lane-index constants LANE0 and LANE1.
- One sub-module, reg_scoreboard, holds:
  - the busy vector;
  - reserve, clear and flush priority logic;
  - the registered popcount.
- The top level holds the data array, write-collision logic, the bypass muxes and the read_busy masking.

Test Plan:
- Reset with all registers written to 0xFFFFFFFF, then reset_n low mid-cycle -> every read_data is 0, busy_count is 0, immediately and without a clock edge.
- Lane0 writes x5=0x11111111 and lane1 writes x5=0x22222222 in the same cycle -> next cycle read x5 = 0x22222222. With BYPASS=1, same-cycle read of x5 = 0x22222222.
- Write x0=0xDEADBEEF plus reserve x0 -> read x0 = 0, read_busy = 0, busy_count = 0.
- Reserve x7; next cycle read x7 -> read_busy = 1, busy_count = 1. Then lane0 writes x7=0x1234 -> same-cycle read_busy = 0 (BYPASS=1), data 0x1234; next cycle busy_count = 0.
- Reserve x3 and lane1 writes x3 in the same cycle -> x3 holds the new data, read_busy(x3) = 1, busy_count = 1.
- Reserve x1, x2, x4 on successive cycles (busy_count = 3), then flush together with reserve x6 and lane0 write x2=0xABCD -> busy_count = 0, x6 not busy, x2 reads 0xABCD.
